addsub_arbiter: RTL

Round-robin arbiter and sequencer that shares one 4-bit add/subtract unit (FAdd_sub) between two requesters. Each requester hands over operands and an operation with a valid/grant handshake. The block drives the shared unit from registers, captures its sum and carry one cycle later, and returns the result on a shared result bus tagged by a one-hot done pulse. It sits between the requesting datapaths and the single arithmetic instance at the top level.

---
 rtl/addsub_arbiter_pkg.sv | 19 +
 rtl/addsub_rr_picker.sv | 26 ++
 rtl/addsub_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the add/subtract arbiter: default operand width,
// FSM state encoding and the operation codes understood by the shared unit.
package addsub_arbiter_pkg;

    localparam int WIDTH_DEFAULT = 4;

    // Sequencer states: waiting for a request, or one operation in flight.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Operation code driven on the shared unit's control input.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/addsub_rr_picker.sv
// Combinational two-way round-robin picker. A lone valid requester always
// wins; on contention the requester that was not served last wins.
module addsub_rr_picker (
    input  logic [1:0] req_valid,
    input  logic       last_served,
    output logic [1:0] winner,
    output logic       winner_id
);

    // Pick the winner and encode its index alongside the one-hot vector.
    always_comb begin
        winner    = 2'b00;
        winner_id = 1'b0;
        if (req_valid == 2'b11) begin
            winner_id = ~last_served;
            winner    = last_served ? 2'b01 : 2'b10;
        end else if (req_valid[0]) begin
            winner_id = 1'b0;
            winner    = 2'b01;
        end else if (req_valid[1]) begin
            winner_id = 1'b1;
            winner    = 2'b10;
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sequencer sharing one external add/subtract unit between two
// requesters. Operands are registered toward the unit at transfer, and the
// unit's sum/carry are captured one cycle later with a one-hot done pulse.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int NREQ  = 2
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic [NREQ-1:0]       req_valid_in,
    input  logic [NREQ*WIDTH-1:0] req_a_in,
    input  logic [NREQ*WIDTH-1:0] req_b_in,
    input  logic [NREQ-1:0]       req_control_in,
    output logic [NREQ-1:0]       grant_out,
    output logic                  busy_out,
    output logic [NREQ-1:0]       done_out,
    output logic [WIDTH-1:0]      res_sum_out,
    output logic                  res_carry_out,
    output logic [WIDTH-1:0]      au_a_out,
    output logic [WIDTH-1:0]      au_b_out,
    output logic                  au_control_out,
    input  logic [WIDTH-1:0]      au_sum_in,
    input  logic                  au_carry_in
);

    state_t             state_reg, state_next;
    logic               last_served_reg;
    logic               id_reg;
    logic               busy_reg;
    logic [NREQ-1:0]    done_reg;
    logic [WIDTH-1:0]   res_sum_reg;
    logic               res_carry_reg;
    logic [WIDTH-1:0]   au_a_reg, au_b_reg;
    op_t                au_op_reg;

    logic [NREQ-1:0]    winner;
    logic               winner_id;
    logic               transfer, capture;
    logic [WIDTH-1:0]   a_vec [NREQ];
    logic [WIDTH-1:0]   b_vec [NREQ];

    // Unpack the per-requester operand lanes.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign a_vec[gi] = req_a_in[gi*WIDTH +: WIDTH];
            assign b_vec[gi] = req_b_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    addsub_rr_picker u_picker (
        .req_valid   (req_valid_in),
        .last_served (last_served_reg),
        .winner      (winner),
        .winner_id   (winner_id)
    );

    // Next-state logic: a winner in IDLE transfers; EXEC always lasts one cycle.
    always_comb begin
        state_next = state_reg;
        transfer   = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|winner) begin
                    transfer   = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture    = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Grant is only offered while idle, so it never overlaps an in-flight op.
    assign grant_out = (state_reg == ST_IDLE) ? winner : '0;

    // State, fairness pointer and the id of the operation in flight.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_reg       <= ST_IDLE;
            last_served_reg <= 1'b1;
            id_reg          <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (transfer) begin
                id_reg <= winner_id;
            end
            if (capture) begin
                last_served_reg <= id_reg;
            end
        end
    end

    // Operand launch toward the shared unit and result capture from it.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            au_a_reg      <= '0;
            au_b_reg      <= '0;
            au_op_reg     <= OP_ADD;
            busy_reg      <= 1'b0;
            done_reg      <= '0;
            res_sum_reg   <= '0;
            res_carry_reg <= 1'b0;
        end else begin
            busy_reg <= transfer;
            done_reg <= capture ? (NREQ'(1) << id_reg) : '0;
            if (transfer) begin
                au_a_reg  <= a_vec[winner_id];
                au_b_reg  <= b_vec[winner_id];
                au_op_reg <= op_t'(req_control_in[winner_id]);
            end
            if (capture) begin
                res_sum_reg   <= au_sum_in;
                res_carry_reg <= au_carry_in;
            end
        end
    end

    assign busy_out       = busy_reg;
    assign done_out       = done_reg;
    assign res_sum_out    = res_sum_reg;
    assign res_carry_out  = res_carry_reg;
    assign au_a_out       = au_a_reg;
    assign au_b_out       = au_b_reg;
    assign au_control_out = au_op_reg;

endmodule
